// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and constants for the SDRAM arbiter
package galaxy_mem_pkg;

    localparam int         DEF_AW       = 25;
    localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef enum logic {
        OP_WR,
        OP_RD
    } op_t;

endpackage

// File: rtl/sdram_arb_if.sv
// rtl/sdram_arb_if.sv - single-port SDRAM controller command/response bundle
interface sdram_arb_if
    import galaxy_mem_pkg::*;
#(
    parameter int AW = DEF_AW
);
    logic [AW-1:0] addr;
    logic [7:0]    din;
    logic          we;
    logic          rd;
    logic [7:0]    dout;
    logic          ready;

    modport master (output addr, din, we, rd, input dout, ready);
    modport slave  (input addr, din, we, rd, output dout, ready);
endinterface

// File: rtl/sdram_arb_req_slot.sv
// rtl/sdram_arb_req_slot.sv - one-entry request capture register with overflow pulse
module req_slot
    import galaxy_mem_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic          full,
    output logic [AW-1:0] addr,
    output logic [7:0]    data,
    output logic          ovf
);
    logic held;

    // A pop in the same cycle frees the entry, so a push then is accepted.
    assign held = full && !pop;
    assign ovf  = push && held;

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (push && !held) begin
            full <= 1'b1;
            addr <= push_addr;
            data <= push_data;
        end else if (pop) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/sdram_arb.sv
// rtl/sdram_arb.sv - arbitrates loader writes and VFD reads onto one SDRAM port
module sdram_arb
    import galaxy_mem_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int TIMEOUT      = 64,
    parameter int WR_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_wr,
    input  logic [AW-1:0]     ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_wait,
    input  logic              rq_rd,
    input  logic [AW-1:0]     rq_addr,
    output logic [7:0]        rq_data,
    output logic              rq_valid,
    output logic              rq_busy,
    sdram_arb_if.master       mem,
    output logic              err_timeout,
    output logic              err_ovf
);
    localparam int CW = $clog2(TIMEOUT);
    localparam int RW = $clog2(WR_BURST_MAX + 1);

    state_t        state, state_nx;
    op_t           op, op_nx;
    logic [CW-1:0] wait_cnt;
    logic [RW-1:0] run_cnt;
    logic          done, timed_out;

    logic          ld_full, ld_pop, ld_ovf;
    logic [AW-1:0] ld_s_addr;
    logic [7:0]    ld_s_data;
    logic          rq_full, rq_pop, rq_ovf;
    logic [AW-1:0] rq_s_addr;
    logic [7:0]    rq_s_data;

    req_slot #(.AW(AW)) u_ld_slot (
        .clk(clk), .reset(reset), .push(ld_wr), .push_addr(ld_addr), .push_data(ld_data),
        .pop(ld_pop), .full(ld_full), .addr(ld_s_addr), .data(ld_s_data), .ovf(ld_ovf)
    );

    req_slot #(.AW(AW)) u_rq_slot (
        .clk(clk), .reset(reset), .push(rq_rd), .push_addr(rq_addr), .push_data(8'h00),
        .pop(rq_pop), .full(rq_full), .addr(rq_s_addr), .data(rq_s_data), .ovf(rq_ovf)
    );

    always_comb begin
        state_nx  = state;
        op_nx     = op;
        ld_pop    = 1'b0;
        rq_pop    = 1'b0;
        done      = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                // A full write run forces the pending read ahead of further writes.
                if (rq_full && run_cnt == RW'(WR_BURST_MAX)) begin
                    rq_pop = 1'b1; op_nx = OP_RD; state_nx = ISSUE;
                end else if (ld_full) begin
                    ld_pop = 1'b1; op_nx = OP_WR; state_nx = ISSUE;
                end else if (rq_full) begin
                    rq_pop = 1'b1; op_nx = OP_RD; state_nx = ISSUE;
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (mem.ready) begin
                    done = 1'b1; state_nx = IDLE;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    timed_out = 1'b1; state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign mem.we  = (state == ISSUE) && (op == OP_WR);
    assign mem.rd  = (state == ISSUE) && (op == OP_RD);
    assign ld_wait = ld_full || ((state != IDLE) && (op == OP_WR));
    assign rq_busy = rq_full || ((state != IDLE) && (op == OP_RD));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op          <= OP_WR;
            wait_cnt    <= '0;
            run_cnt     <= '0;
            mem.addr    <= '0;
            mem.din     <= '0;
            rq_data     <= 8'h00;
            rq_valid    <= 1'b0;
            err_timeout <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            state    <= state_nx;
            op       <= op_nx;
            rq_valid <= 1'b0;
            wait_cnt <= (state == WAIT && state_nx == WAIT) ? wait_cnt + 1'b1 : '0;
            if (ld_pop) begin
                mem.addr <= ld_s_addr;
                mem.din  <= ld_s_data;
                if (run_cnt != RW'(WR_BURST_MAX))
                    run_cnt <= run_cnt + 1'b1;
            end
            if (rq_pop) begin
                mem.addr <= rq_s_addr;
                mem.din  <= rq_s_data;
                run_cnt  <= '0;
            end
            if (op == OP_RD && (done || timed_out)) begin
                rq_valid <= 1'b1;
                rq_data  <= done ? mem.dout : TIMEOUT_FILL;
            end
            if (timed_out)
                err_timeout <= 1'b1;
            if (ld_ovf || rq_ovf)
                err_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sdram_arb.sv
// tb/tb_sdram_arb.sv - directed vector bench for sdram_arb with a scripted SDRAM responder
module tb_sdram_arb;
    logic        clk;
    logic        reset;
    logic        ld_wr, rq_rd;
    logic [24:0] ld_addr, rq_addr;
    logic [7:0]  ld_data;
    logic        ld_wait, rq_valid, rq_busy, err_timeout, err_ovf;
    logic [7:0]  rq_data;

    sdram_arb_if #(.AW(25)) mem_if ();

    sdram_arb #(.AW(25), .TIMEOUT(64), .WR_BURST_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_wait(ld_wait),
        .rq_rd(rq_rd), .rq_addr(rq_addr), .rq_data(rq_data), .rq_valid(rq_valid), .rq_busy(rq_busy),
        .mem(mem_if), .err_timeout(err_timeout), .err_ovf(err_ovf)
    );

    typedef struct {
        logic        rd;
        logic [24:0] addr;
        logic [7:0]  data;
        int          lat;
        logic [7:0]  rval;
        logic [7:0]  exp_rdata;
        int          exp_done;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    logic [7:0] rd_val = 8'h00;
    logic mute = 1'b0;
    logic        log_op[$];
    logic [24:0] log_addr[$];
    int          log_cyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // SDRAM model: answers each strobe with mem_ready 'lat' cycles later unless muted.
    initial begin
        int cnt;
        logic [7:0] pend;
        cnt = 0;
        pend = 8'h00;
        mem_if.ready = 1'b0;
        mem_if.dout  = 8'h00;
        forever begin
            @(negedge clk);
            mem_if.ready = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mem_if.ready = 1'b1;
                    mem_if.dout  = pend;
                end
            end
            if (mem_if.rd || mem_if.we) begin
                log_op.push_back(mem_if.rd);
                log_addr.push_back(mem_if.addr);
                log_cyc.push_back(cyc);
                if (!mute) begin
                    cnt  = lat;
                    pend = rd_val;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        log_op.delete();
        log_addr.delete();
        log_cyc.delete();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int done_at;
        lat = v.lat;
        rd_val = v.rval;
        if (v.rd) begin rq_rd = 1'b1; rq_addr = v.addr; end
        else begin ld_wr = 1'b1; ld_addr = v.addr; ld_data = v.data; end
        @(negedge clk);
        rq_rd = 1'b0; ld_wr = 1'b0;
        chk({tag, "_flag"}, 32'(v.rd ? rq_busy : ld_wait), 32'd1);
        @(negedge clk);
        chk({tag, "_strobe"}, 32'(v.rd ? mem_if.rd : mem_if.we), 32'd1);
        chk({tag, "_addr"}, 32'(mem_if.addr), 32'(v.addr));
        if (!v.rd) chk({tag, "_din"}, 32'(mem_if.din), 32'(v.data));
        done_at = -1;
        for (int k = 3; k <= v.exp_done + 4 && done_at < 0; k++) begin
            @(negedge clk);
            if (v.rd ? rq_valid : !ld_wait) begin
                done_at = k;
                if (v.rd) chk({tag, "_rdata"}, 32'(rq_data), 32'(v.exp_rdata));
            end
        end
        chk({tag, "_latency"}, done_at, v.exp_done);
        @(negedge clk);
        chk({tag, "_valid_pulse"}, 32'(rq_valid), 32'd0);
        chk({tag, "_idle_flags"}, 32'({ld_wait, rq_busy}), 32'd0);
        if (v.rd) chk({tag, "_rdata_hold"}, 32'(rq_data), 32'(v.exp_rdata));
    endtask

    initial begin
        vec_t vecs[5];
        vec_t post;
        int t0, wl, vl, sent, nv;
        logic        exp_op[6];
        logic [24:0] exp_addr[6];

        //          rd    addr           data   lat rval   exp    done
        vecs[0] = '{1'b1, 25'h000123,    8'h00, 3, 8'h5A, 8'h5A, 6};
        vecs[1] = '{1'b0, 25'h0000010,   8'h77, 1, 8'h00, 8'h00, 4};
        vecs[2] = '{1'b1, 25'h1FFFFFF,   8'h00, 1, 8'h00, 8'h00, 4};
        vecs[3] = '{1'b0, 25'h1FFFFFF,   8'hFF, 5, 8'h00, 8'h00, 8};
        vecs[4] = '{1'b1, 25'h0000000,   8'h00, 2, 8'hC3, 8'hC3, 5};
        post    = '{1'b1, 25'h0000600,   8'h00, 2, 8'h3C, 8'h3C, 5};

        reset = 1'b1; ld_wr = 1'b0; rq_rd = 1'b0;
        ld_addr = '0; rq_addr = '0; ld_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_outputs", 32'({ld_wait, rq_busy, rq_valid, err_timeout, err_ovf, mem_if.we, mem_if.rd}), 32'd0);
        chk("rst_rq_data", 32'(rq_data), 32'd0);
        chk("rst_mem_addr", 32'(mem_if.addr), 32'd0);
        chk("rst_mem_din", 32'(mem_if.din), 32'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // simultaneous strobes: write first, then read
        clear_log();
        lat = 2; rd_val = 8'h11;
        ld_wr = 1'b1; ld_addr = 25'd10; ld_data = 8'h77;
        rq_rd = 1'b1; rq_addr = 25'd20;
        t0 = cyc;
        wl = -1; vl = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            ld_wr = 1'b0; rq_rd = 1'b0;
            if (wl < 0 && !ld_wait) wl = k;
            if (vl < 0 && rq_valid) vl = k;
        end
        chk("sim_nops", log_op.size(), 2);
        if (log_op.size() >= 2) begin
            chk("sim_first_op", 32'(log_op[0]), 32'd0);
            chk("sim_first_addr", 32'(log_addr[0]), 32'd10);
            chk("sim_first_cyc", log_cyc[0] - t0, 2);
            chk("sim_second_op", 32'(log_op[1]), 32'd1);
            chk("sim_second_addr", 32'(log_addr[1]), 32'd20);
            chk("sim_second_cyc", log_cyc[1] - t0, 6);
        end
        chk("sim_ld_wait_release", wl, 5);
        chk("sim_rq_valid_cyc", vl, 9);
        chk("sim_rq_data", 32'(rq_data), 32'h11);

        // starvation guard: loader refills during every write issue
        clear_log();
        lat = 1; rd_val = 8'h66;
        exp_op   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_addr = '{25'd100, 25'd101, 25'd102, 25'd103, 25'd200, 25'd104};
        ld_wr = 1'b1; ld_addr = 25'd100; ld_data = 8'd0;
        rq_rd = 1'b1; rq_addr = 25'd200;
        sent = 1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            ld_wr = 1'b0; rq_rd = 1'b0;
            if (mem_if.we && sent < 5) begin
                ld_wr = 1'b1; ld_addr = 25'(100 + sent); ld_data = 8'(sent);
                sent++;
            end
        end
        nv = log_op.size();
        chk("starve_nops", nv, 6);
        for (int i = 0; i < 6 && i < nv; i++) begin
            chk($sformatf("starve_op%0d", i), 32'(log_op[i]), 32'(exp_op[i]));
            chk($sformatf("starve_addr%0d", i), 32'(log_addr[i]), 32'(exp_addr[i]));
        end
        chk("starve_rq_data", 32'(rq_data), 32'h66);
        chk("starve_no_ovf", 32'(err_ovf), 32'd0);

        // timeout on a read
        chk("to_err_before", 32'(err_timeout), 32'd0);
        mute = 1'b1;
        rq_rd = 1'b1; rq_addr = 25'd55;
        vl = -1;
        for (int k = 1; k <= 80 && vl < 0; k++) begin
            @(negedge clk);
            rq_rd = 1'b0;
            if (rq_valid) vl = k;
        end
        chk("to_valid_cyc", vl, 67);
        chk("to_rq_data", 32'(rq_data), 32'hFF);
        chk("to_err_set", 32'(err_timeout), 32'd1);
        mute = 1'b0;
        repeat (5) @(negedge clk);
        chk("to_err_sticky", 32'(err_timeout), 32'd1);

        // overflow: second read strobe while first waits behind a write
        clear_log();
        lat = 4; rd_val = 8'h4D;
        chk("ovf_before", 32'(err_ovf), 32'd0);
        ld_wr = 1'b1; ld_addr = 25'd400; ld_data = 8'h12;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            ld_wr = 1'b0; rq_rd = 1'b0;
            if (k == 2) begin rq_rd = 1'b1; rq_addr = 25'd300; end
            if (k == 3) begin rq_rd = 1'b1; rq_addr = 25'd301; end
        end
        chk("ovf_set", 32'(err_ovf), 32'd1);
        chk("ovf_nops", log_op.size(), 2);
        if (log_op.size() >= 2) begin
            chk("ovf_rd_op", 32'(log_op[1]), 32'd1);
            chk("ovf_rd_addr", 32'(log_addr[1]), 32'd300);
        end
        chk("ovf_rq_data", 32'(rq_data), 32'h4D);

        // reset mid-read, late mem_ready must be ignored
        lat = 5; rd_val = 8'h99;
        rq_rd = 1'b1; rq_addr = 25'd500;
        vl = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            rq_rd = 1'b0;
            reset = (k == 4);
            if (k == 5) begin
                chk("rw_flags", 32'({ld_wait, rq_busy, rq_valid, err_timeout, err_ovf, mem_if.we, mem_if.rd}), 32'd0);
                chk("rw_rq_data", 32'(rq_data), 32'd0);
                chk("rw_mem_addr", 32'(mem_if.addr), 32'd0);
            end
            if (k >= 5 && rq_valid) vl++;
        end
        chk("rw_no_valid", vl, 0);
        chk("rw_rq_data_kept", 32'(rq_data), 32'd0);
        run_vec(post, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
